// File: rtl/ram_1rw_slp_gen_if.sv
// Access/status bundle for ram_1rw_slp_gen: request, write data/mask,
// sleep request, fuse inputs; read data and ready back to the master.
interface ram_1rw_slp_gen_if #(
  parameter int DW = 32,
  parameter int AW = 14
);
  logic          ce;
  logic          we;
  logic [AW-1:0] ia;
  logic [DW-1:0] i;
  logic [DW-1:0] dm;
  logic [DW-1:0] a;
  logic          slp;
  logic          fo_en;
  logic [AW-1:0] fo_row;
  logic          rdy;

  modport master (
    output ce, we, ia, i, dm,
    output slp, fo_en, fo_row,
    input  a, rdy
  );

  modport slave (
    input  ce, we, ia, i, dm,
    input  slp, fo_en, fo_row,
    output a, rdy
  );
endinterface

// File: rtl/ram_1rw_slp_gen.sv
// 1RW synchronous RAM: bit-masked writes, sleep/wake sequencing, one spare row.
// Ports: clk, rst (async, high), bus (slave: ce/we/ia/i/dm/slp/fo_* in, a/rdy out).
module ram_1rw_slp_gen #(
  parameter int DW          = 32,
  parameter int AW          = 14,
  parameter int DEPTH       = 2**AW,
  parameter int WAKE_CYCLES = 4
) (
  input logic               clk,
  input logic               rst,
  ram_1rw_slp_gen_if.slave  bus
);

  localparam int CW = (WAKE_CYCLES > 1) ? $clog2(WAKE_CYCLES) : 1;
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(WAKE_CYCLES - 1);
  localparam logic [AW:0]   DEPTH_W  = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {
    ACTIVE,
    SLEEP,
    WAKE
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          fo_en_q;
  logic [AW-1:0] fo_row_q;
  logic [DW-1:0] a_q;
  logic          rdy_q;

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] spare;

  logic          accept;
  logic          in_rng;
  logic          hit;
  logic          wr;
  logic          rd;
  logic [IW-1:0] idx;
  logic [DW-1:0] row_q;
  logic [DW-1:0] row_d;

  // SLP wins over a same-cycle access; the spare row only
  // answers for a latched row that actually exists.
  always_comb begin
    accept = rdy_q & bus.ce & ~bus.slp;
    in_rng = {1'b0, bus.ia} < DEPTH_W;
    hit    = fo_en_q
           & (bus.ia == fo_row_q)
           & ({1'b0, fo_row_q} < DEPTH_W);
    idx    = bus.ia[IW-1:0];
    row_q  = hit ? spare : mem[idx];
    row_d  = (row_q & bus.dm) | (bus.i & ~bus.dm);
    wr     = accept & bus.we & in_rng;
    rd     = accept & ~bus.we;
  end

  // Storage carries no reset; rdy_q drops asynchronously,
  // which kills any access caught by a reset.
  always_ff @(posedge clk) begin
    if (wr) begin
      if (hit) spare    <= row_d;
      else     mem[idx] <= row_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= WAKE;
      cnt      <= CNT_INIT;
      fo_en_q  <= 1'b0;
      fo_row_q <= '0;
      a_q      <= '0;
      rdy_q    <= 1'b0;
    end else begin
      if (rd) a_q <= in_rng ? row_q : '0;
      unique case (state)
        ACTIVE: begin
          if (bus.slp) begin
            state <= SLEEP;
            rdy_q <= 1'b0;
            a_q   <= '0;
          end
        end
        SLEEP: begin
          if (!bus.slp) begin
            state <= WAKE;
            cnt   <= CNT_INIT;
          end
        end
        WAKE: begin
          // fuses follow the pins only while waking
          fo_en_q  <= bus.fo_en;
          fo_row_q <= bus.fo_row;
          if (bus.slp) begin
            state <= SLEEP;
            a_q   <= '0;
          end else if (cnt == '0) begin
            state <= ACTIVE;
            rdy_q <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          state <= WAKE;
          cnt   <= CNT_INIT;
          rdy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.a   = a_q;
  assign bus.rdy = rdy_q;

endmodule

// File: tb/tb_ram_1rw_slp_gen.sv
// Directed + random bench for ram_1rw_slp_gen against a behavioural model.
// DEPTH=1000 with AW=10 so out-of-range addresses are reachable.
module tb_ram_1rw_slp_gen;

  localparam int DW    = 32;
  localparam int AW    = 10;
  localparam int DEPTH = 1000;
  localparam int WC    = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ram_1rw_slp_gen_if #(.DW(DW), .AW(AW)) bus ();

  ram_1rw_slp_gen #(
    .DW(DW), .AW(AW), .DEPTH(DEPTH), .WAKE_CYCLES(WC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] m_mem [int];
  logic [DW-1:0] m_spare;
  bit            m_sleep;
  int            m_wait;
  bit            m_fen;
  int            m_frow;
  logic [DW-1:0] m_a;

  function automatic bit m_rdy();
    return !m_sleep && m_wait == 0;
  endfunction

  task automatic check(string tag, logic [DW-1:0] got,
                       logic [DW-1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic m_reset();
    m_sleep = 1'b0;
    m_wait  = WC;
    m_fen   = 1'b0;
    m_frow  = 0;
    m_a     = '0;
  endtask

  task automatic m_edge();
    int            ia;
    bit            acc_ok;
    bit            remap;
    logic [DW-1:0] old;
    logic [DW-1:0] nv;
    ia     = int'(bus.ia);
    acc_ok = m_rdy() && bus.ce && !bus.slp;
    remap  = m_fen && (m_frow == ia) && (m_frow < DEPTH);
    if (acc_ok) begin
      if (ia >= DEPTH) begin
        if (!bus.we) m_a = '0;
      end else begin
        old = remap ? m_spare : m_mem[ia];
        if (bus.we) begin
          for (int b = 0; b < DW; b++)
            nv[b] = bus.dm[b] ? old[b] : bus.i[b];
          if (remap) m_spare = nv;
          else       m_mem[ia] = nv;
        end else begin
          m_a = old;
        end
      end
    end
    if (m_sleep) begin
      if (!bus.slp) begin
        m_sleep = 1'b0;
        m_wait  = WC;
      end
    end else if (m_wait == 0) begin
      if (bus.slp) begin
        m_sleep = 1'b1;
        m_a     = '0;
      end
    end else begin
      m_fen  = bus.fo_en;
      m_frow = int'(bus.fo_row);
      if (bus.slp) begin
        m_sleep = 1'b1;
        m_a     = '0;
      end else begin
        m_wait--;
      end
    end
  endtask

  task automatic step(string tag);
    m_edge();
    @(posedge clk);
    #1;
    check({tag, " rdy"}, DW'(bus.rdy), DW'(m_rdy()));
    check({tag, " a"}, bus.a, m_a);
  endtask

  task automatic acc(bit ce, bit we, int ia,
                     logic [DW-1:0] d, logic [DW-1:0] m);
    bus.ce = ce;
    bus.we = we;
    bus.ia = AW'(ia);
    bus.i  = d;
    bus.dm = m;
  endtask

  task automatic sleep_wake(string tag);
    acc(0, 0, 0, '0, '0);
    bus.slp = 1'b1;
    step(tag);
    step(tag);
    bus.slp = 1'b0;
    repeat (WC + 1) step(tag);
    check({tag, " awake"}, DW'(bus.rdy), 32'd1);
  endtask

  initial begin
    acc(0, 0, 0, '0, '0);
    bus.slp    = 1'b0;
    bus.fo_en  = 1'b0;
    bus.fo_row = '0;
    m_reset();
    #1;
    check("reset rdy", DW'(bus.rdy), 32'd0);
    check("reset a", bus.a, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // wake-up latency after reset
    repeat (WC - 1) step("t1");
    check("t1 not yet", DW'(bus.rdy), 32'd0);
    step("t1");
    check("t1 ready", DW'(bus.rdy), 32'd1);

    // masked write then read
    acc(1, 1, 5, 32'hDEADBEEF, 32'h0);
    step("t2 w1");
    acc(1, 1, 5, 32'h0, 32'hFFFF0000);
    step("t2 w2");
    acc(1, 0, 5, '0, '0);
    step("t2 rd");
    check("t2 data", bus.a, 32'hDEAD0000);
    acc(0, 0, 0, '0, '0);
    repeat (3) step("t2 hold");
    check("t2 held", bus.a, 32'hDEAD0000);

    // spare-row remap
    acc(1, 1, 7, 32'h77777777, 32'h0);
    step("t3 w7");
    bus.fo_en  = 1'b1;
    bus.fo_row = AW'(7);
    sleep_wake("t3 sw1");
    acc(1, 1, 7, 32'h11111111, 32'h0);
    step("t3 wsp");
    acc(1, 0, 7, '0, '0);
    step("t3 rsp");
    check("t3 spare", bus.a, 32'h11111111);
    bus.fo_en = 1'b0;
    sleep_wake("t3 sw2");
    acc(1, 0, 7, '0, '0);
    step("t3 rarr");
    check("t3 array", bus.a, 32'h77777777);
    bus.fo_en = 1'b1;
    sleep_wake("t3 sw3");
    acc(1, 0, 7, '0, '0);
    step("t3 rsp2");
    check("t3 respare", bus.a, 32'h11111111);
    bus.fo_en = 1'b0;

    // access dropped in the sleep-rise cycle, retention
    acc(1, 1, 3, 32'h33333333, 32'h0);
    step("t4 w3");
    acc(1, 0, 5, '0, '0);
    step("t4 r5");
    acc(1, 1, 3, 32'hAAAA5555, 32'h0);
    bus.slp = 1'b1;
    step("t4 drop");
    check("t4 rdy0", DW'(bus.rdy), 32'd0);
    check("t4 a0", bus.a, 32'd0);
    acc(0, 0, 0, '0, '0);
    step("t4 slp");
    bus.slp = 1'b0;
    repeat (WC) step("t4 wake");
    check("t4 not yet", DW'(bus.rdy), 32'd0);
    step("t4 wake");
    check("t4 ready", DW'(bus.rdy), 32'd1);
    acc(1, 0, 3, '0, '0);
    step("t4 r3");
    check("t4 retain", bus.a, 32'h33333333);

    // sleep pulse during wake restarts the count
    acc(0, 0, 0, '0, '0);
    bus.slp = 1'b1;
    step("t5");
    bus.slp = 1'b0;
    repeat (3) step("t5");
    bus.slp = 1'b1;
    step("t5 pulse");
    bus.slp = 1'b0;
    repeat (WC) step("t5 wake");
    check("t5 not yet", DW'(bus.rdy), 32'd0);
    step("t5 wake");
    check("t5 ready", DW'(bus.rdy), 32'd1);

    // out-of-range address, CE=0 hold
    acc(1, 0, 5, '0, '0);
    step("t6 r5");
    acc(1, 1, 1010, 32'hCAFEF00D, 32'h0);
    step("t6 woor");
    check("t6 hold", bus.a, 32'hDEAD0000);
    acc(1, 0, 1010, '0, '0);
    step("t6 roor");
    check("t6 oor", bus.a, 32'd0);
    acc(1, 0, 5, '0, '0);
    step("t6 r5b");
    for (int k = 0; k < 6; k++) begin
      acc(0, k % 2, $urandom_range(0, 1023),
          $urandom, $urandom);
      step("t6 ce0");
    end
    check("t6 ce0 hold", bus.a, 32'hDEAD0000);

    // random traffic
    for (int r = 0; r < 16; r++) begin
      acc(1, 1, r, $urandom, 32'h0);
      step("rnd fill");
    end
    for (int k = 0; k < 600; k++) begin
      acc($urandom_range(0, 3) != 0, $urandom_range(0, 1),
          ($urandom_range(0, 7) == 0)
            ? 1000 + $urandom_range(0, 23)
            : $urandom_range(0, 15),
          $urandom, $urandom);
      if ($urandom_range(0, 24) == 0) bus.slp = ~bus.slp;
      bus.fo_en  = 1'($urandom_range(0, 1));
      bus.fo_row = ($urandom_range(0, 3) == 0)
                     ? AW'(1005)
                     : AW'($urandom_range(0, 15));
      step("rnd");
    end
    acc(0, 0, 0, '0, '0);
    bus.slp = 1'b0;
    repeat (WC + 2) step("rnd settle");

    // asynchronous reset mid-access
    acc(1, 0, 2, '0, '0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    m_reset();
    check("rst a", bus.a, 32'd0);
    check("rst rdy", DW'(bus.rdy), 32'd0);
    @(posedge clk);
    #1;
    check("rst hold a", bus.a, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    acc(0, 0, 0, '0, '0);
    repeat (WC) step("rst wake");
    for (int r = 0; r < 16; r++) begin
      acc(1, 0, r, '0, '0);
      step("rst keep");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
